// File: rtl/nonce_search_if.sv
// Request/result bundle for the nonce_search engine.
// i_block[n] carries header byte n (block0..11); o_nonce[n] carries result byte n (nonce0 = LSB).
interface nonce_search_if;
    logic             i_start;
    logic [11:0][7:0] i_block;
    logic [15:0]      i_target;
    logic             o_finish;
    logic             o_found;
    logic [3:0][7:0]  o_nonce;

    modport master (output i_start, i_block, i_target,
                    input  o_finish, o_found, o_nonce);
    modport slave  (input  i_start, i_block, i_target,
                    output o_finish, o_found, o_nonce);
endinterface

// File: rtl/nonce_search.sv
// Proof-of-work search: walks a 32-bit nonce from zero, one 16-round byte hash per
// nonce (17 cycles each), stopping on the first digest strictly below the target.
module nonce_search #(
    parameter logic [31:0] MAX_NONCE = 32'hFFFF_FFFF
) (
    input  logic           i_clk,
    input  logic           i_reset,
    nonce_search_if.slave  bus
);
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ROUND_W   = 4;
    localparam int unsigned NONCE_W   = 32;
    localparam int unsigned DIG_W     = 16;
    localparam int unsigned BLK_BYTES = 12;
    localparam int unsigned WORDS     = 16;

    localparam logic [BYTE_W-1:0]  A_INIT     = 8'h01;
    localparam logic [BYTE_W-1:0]  B_INIT     = 8'h89;
    localparam logic [BYTE_W-1:0]  C_INIT     = 8'hFE;
    localparam logic [ROUND_W-1:0] LAST_ROUND = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_HASH, S_CMP, S_DONE} state_t;

    state_t                               r_state, w_state;
    logic [BLK_BYTES-1:0][BYTE_W-1:0]     r_blk, w_blk;
    logic [DIG_W-1:0]                     r_target, w_target;
    logic [NONCE_W-1:0]                   r_nonce, w_nonce;
    logic [ROUND_W-1:0]                   r_round, w_round;
    logic [BYTE_W-1:0]                    r_a, r_b, r_c, w_a, w_b, w_c;
    logic                                 r_finish, w_finish;
    logic                                 r_found, w_found;
    logic [NONCE_W-1:0]                   r_nonce_out, w_nonce_out;

    // Message schedule: words 0..11 are the header, 12..15 the nonce bytes LSB first.
    logic [WORDS-1:0][BYTE_W-1:0]         w_words;
    logic [BYTE_W-1:0]                    w_k;
    logic [DIG_W-1:0]                     w_digest;

    assign w_words  = {r_nonce, r_blk};
    assign w_k      = w_words[r_round];
    assign w_digest = {r_b, r_c};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_blk       <= '0;
            r_target    <= '0;
            r_nonce     <= '0;
            r_round     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_finish    <= 1'b0;
            r_found     <= 1'b0;
            r_nonce_out <= '0;
        end else begin
            r_state     <= w_state;
            r_blk       <= w_blk;
            r_target    <= w_target;
            r_nonce     <= w_nonce;
            r_round     <= w_round;
            r_a         <= w_a;
            r_b         <= w_b;
            r_c         <= w_c;
            r_finish    <= w_finish;
            r_found     <= w_found;
            r_nonce_out <= w_nonce_out;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_blk       = r_blk;
        w_target    = r_target;
        w_nonce     = r_nonce;
        w_round     = r_round;
        w_a         = r_a;
        w_b         = r_b;
        w_c         = r_c;
        w_found     = r_found;
        w_nonce_out = r_nonce_out;
        // finish rises the cycle after DONE is entered and drops with start
        w_finish    = (r_state == S_DONE) && bus.i_start;

        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_blk    = bus.i_block;
                    w_target = bus.i_target;
                    w_nonce  = '0;
                    w_a      = A_INIT;
                    w_b      = B_INIT;
                    w_c      = C_INIT;
                    w_round  = '0;
                    w_state  = S_HASH;
                end
            end
            S_HASH: begin
                if (!bus.i_start) begin
                    w_state = S_IDLE;
                end else begin
                    w_a     = r_b;
                    w_b     = r_c ^ w_k;
                    w_c     = r_a + r_b + {w_k[4:0], w_k[7:5]};
                    w_round = r_round + ROUND_W'(1);
                    if (r_round == LAST_ROUND) w_state = S_CMP;
                end
            end
            S_CMP: begin
                if (!bus.i_start) begin
                    w_state = S_IDLE;
                end else if (w_digest < r_target) begin
                    w_found     = 1'b1;
                    w_nonce_out = r_nonce;
                    w_state     = S_DONE;
                end else if (r_nonce == MAX_NONCE) begin
                    w_found     = 1'b0;
                    w_nonce_out = r_nonce;
                    w_state     = S_DONE;
                end else begin
                    w_nonce = r_nonce + NONCE_W'(1);
                    w_a     = A_INIT;
                    w_b     = B_INIT;
                    w_c     = C_INIT;
                    w_round = '0;
                    w_state = S_HASH;
                end
            end
            S_DONE: begin
                if (!bus.i_start) begin
                    w_found = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.o_finish = r_finish;
    assign bus.o_found  = r_found;
    assign bus.o_nonce  = r_nonce_out;
endmodule

// File: tb/tb_nonce_search.sv
// Scoreboard bench for nonce_search: three instances with small MAX_NONCE overrides
// so exhaustion and long searches stay short.
module tb_nonce_search;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nonce_search_if if_a ();
    nonce_search_if if_b ();
    nonce_search_if if_c ();

    nonce_search #(.MAX_NONCE(32'd0))    dut_a (.i_clk(clk), .i_reset(rst), .bus(if_a));
    nonce_search #(.MAX_NONCE(32'd3))    dut_b (.i_clk(clk), .i_reset(rst), .bus(if_b));
    nonce_search #(.MAX_NONCE(32'd1500)) dut_c (.i_clk(clk), .i_reset(rst), .bus(if_c));

    localparam logic [31:0] MAX_A = 32'd0;
    localparam logic [31:0] MAX_B = 32'd3;
    localparam logic [31:0] MAX_C = 32'd1500;

    logic [11:0][7:0] blk;
    logic [15:0]      tgt;
    logic [2:0]       go;

    assign if_a.i_block = blk;  assign if_a.i_target = tgt;  assign if_a.i_start = go[0];
    assign if_b.i_block = blk;  assign if_b.i_target = tgt;  assign if_b.i_start = go[1];
    assign if_c.i_block = blk;  assign if_c.i_target = tgt;  assign if_c.i_start = go[2];

    int          sel;
    logic        obs_finish, obs_found;
    logic [31:0] obs_nonce;

    always_comb begin
        obs_finish = if_a.o_finish;
        obs_found  = if_a.o_found;
        obs_nonce  = if_a.o_nonce;
        case (sel)
            1: begin obs_finish = if_b.o_finish; obs_found = if_b.o_found; obs_nonce = if_b.o_nonce; end
            2: begin obs_finish = if_c.o_finish; obs_found = if_c.o_found; obs_nonce = if_c.o_nonce; end
            default: ;
        endcase
    end

    typedef struct {
        logic        found;
        logic [31:0] nonce;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    logic [11:0][7:0] zero_blk = '0;

    function automatic logic [15:0] model_hash(logic [11:0][7:0] b, logic [31:0] n);
        logic [7:0] a, bb, c, k, t;
        a = 8'h01; bb = 8'h89; c = 8'hFE;
        for (int i = 0; i < 16; i++) begin
            if (i < 12) k = b[i];
            else        k = n[8*(i-12) +: 8];
            t  = a + bb + {k[4:0], k[7:5]};
            a  = bb;
            bb = c ^ k;
            c  = t;
        end
        return {bb, c};
    endfunction

    function automatic exp_t model_search(logic [11:0][7:0] b, logic [15:0] t, logic [31:0] mx);
        exp_t e;
        logic [31:0] n = '0;
        forever begin
            if (model_hash(b, n) < t) begin e.found = 1'b1; break; end
            if (n == mx)              begin e.found = 1'b0; break; end
            n++;
        end
        e.nonce = n;
        e.lat   = 17 * (int'(n) + 1) + 1;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a new request and record what the search must report.
    task automatic launch(int s, logic [11:0][7:0] b, logic [15:0] t, logic [31:0] mx);
        sel = s;
        blk = b;
        tgt = t;
        sb.push_back(model_search(b, t, mx));
        go[s] = 1'b1;
    endtask

    // Edges counted from the latching edge; -1 means the budget ran out.
    task automatic await_finish(int start_cnt, int budget, output int lat);
        int cnt = start_cnt;
        while (!obs_finish && cnt < budget) begin
            step();
            cnt++;
        end
        lat = obs_finish ? cnt - 1 : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; go = '0; blk = '0; tgt = '0; sel = 0;
        step(); step();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks += 3;
            if (obs_finish !== 1'b0) begin errors++; $display("FAIL reset_finish dut%0d got=%b exp=0", s, obs_finish); end
            if (obs_found  !== 1'b0) begin errors++; $display("FAIL reset_found dut%0d got=%b exp=0", s, obs_found); end
            if (obs_nonce  !== 32'd0) begin errors++; $display("FAIL reset_nonce dut%0d got=%h exp=0", s, obs_nonce); end
        end
    endtask

    task automatic test_found_nonce0();
        int lat; exp_t e; logic bad = 1'b0;
        launch(1, zero_blk, 16'hAA0C, MAX_B);
        await_finish(0, 200, lat);
        e = sb.pop_front();
        checks += 3;
        if (lat !== e.lat)           begin errors++; $display("FAIL found0_latency got=%0d exp=%0d", lat, e.lat); end
        if (obs_found !== e.found)   begin errors++; $display("FAIL found0_found got=%b exp=%b", obs_found, e.found); end
        if (obs_nonce !== e.nonce)   begin errors++; $display("FAIL found0_nonce got=%h exp=%h", obs_nonce, e.nonce); end
        // start held high through DONE must not restart the search
        for (int i = 0; i < 40; i++) begin
            step();
            if (obs_finish !== 1'b1 || obs_found !== e.found || obs_nonce !== e.nonce) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL hold_start got=unstable exp=stable"); end
        go[1] = 1'b0;
        step();
        checks += 2;
        if (obs_finish !== 1'b0) begin errors++; $display("FAIL drop_finish got=%b exp=0", obs_finish); end
        if (obs_found  !== 1'b0) begin errors++; $display("FAIL drop_found got=%b exp=0", obs_found); end
    endtask

    task automatic test_strict_compare();
        int lat; exp_t e;
        launch(0, zero_blk, 16'hAA0B, MAX_A);
        await_finish(0, 200, lat);
        e = sb.pop_front();
        checks += 3;
        if (lat !== e.lat)         begin errors++; $display("FAIL strict_latency got=%0d exp=%0d", lat, e.lat); end
        if (obs_found !== e.found) begin errors++; $display("FAIL strict_found got=%b exp=%b", obs_found, e.found); end
        if (obs_nonce !== e.nonce) begin errors++; $display("FAIL strict_nonce got=%h exp=%h", obs_nonce, e.nonce); end
        go[0] = 1'b0;
        step();
    endtask

    task automatic test_random_block();
        int lat; exp_t e;
        logic [7:0] rb [12] = '{8'heb, 8'had, 8'h50, 8'h90, 8'h38, 8'h43,
                               8'hf9, 8'hc9, 8'haa, 8'had, 8'h6f, 8'h64};
        logic [11:0][7:0] b;
        for (int i = 0; i < 12; i++) b[i] = rb[i];
        launch(2, b, 16'd50, MAX_C);
        step();
        // header/target changes after the latching edge must be ignored
        blk = '1;
        tgt = 16'hFFFF;
        await_finish(1, 17 * 1502 + 20, lat);
        e = sb.pop_front();
        checks += 3;
        if (lat !== e.lat)         begin errors++; $display("FAIL rand_latency got=%0d exp=%0d", lat, e.lat); end
        if (obs_found !== e.found) begin errors++; $display("FAIL rand_found got=%b exp=%b", obs_found, e.found); end
        if (obs_nonce !== e.nonce) begin errors++; $display("FAIL rand_nonce got=%h exp=%h", obs_nonce, e.nonce); end
        go[2] = 1'b0;
        step();
    endtask

    task automatic test_exhaust();
        int lat; exp_t e;
        launch(1, zero_blk, 16'd0, MAX_B);
        await_finish(0, 200, lat);
        e = sb.pop_front();
        checks += 3;
        if (lat !== e.lat)         begin errors++; $display("FAIL exhaust_latency got=%0d exp=%0d", lat, e.lat); end
        if (obs_found !== e.found) begin errors++; $display("FAIL exhaust_found got=%b exp=%b", obs_found, e.found); end
        if (obs_nonce !== e.nonce) begin errors++; $display("FAIL exhaust_nonce got=%h exp=%h", obs_nonce, e.nonce); end
        go[1] = 1'b0;
        step();
        checks++;
        if (obs_finish !== 1'b0) begin errors++; $display("FAIL exhaust_drop got=%b exp=0", obs_finish); end
    endtask

    task automatic test_abort_restart();
        int lat; exp_t e; logic seen = 1'b0;
        sel = 1; blk = '0; tgt = 16'hAA0C;
        go[1] = 1'b1;
        for (int i = 0; i < 10; i++) step();
        go[1] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (obs_finish !== 1'b0) seen = 1'b1;
        end
        checks += 2;
        if (seen)                 begin errors++; $display("FAIL abort_finish got=1 exp=0"); end
        if (obs_nonce !== MAX_B)  begin errors++; $display("FAIL abort_nonce got=%h exp=%h", obs_nonce, MAX_B); end
        launch(1, zero_blk, 16'hAA0C, MAX_B);
        await_finish(0, 200, lat);
        e = sb.pop_front();
        checks += 3;
        if (lat !== e.lat)         begin errors++; $display("FAIL restart_latency got=%0d exp=%0d", lat, e.lat); end
        if (obs_found !== e.found) begin errors++; $display("FAIL restart_found got=%b exp=%b", obs_found, e.found); end
        if (obs_nonce !== e.nonce) begin errors++; $display("FAIL restart_nonce got=%h exp=%h", obs_nonce, e.nonce); end
        go[1] = 1'b0;
        step();
    endtask

    task automatic test_reset_priority();
        int lat; exp_t e;
        // leave nonce=3 on the outputs, then reset in the middle of the next hash
        launch(1, zero_blk, 16'd0, MAX_B);
        await_finish(0, 200, lat);
        e = sb.pop_front();
        checks++;
        if (obs_nonce !== e.nonce) begin errors++; $display("FAIL prereset_nonce got=%h exp=%h", obs_nonce, e.nonce); end
        go[1] = 1'b0;
        step();
        go[1] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1; go[1] = 1'b0;
        step();
        rst = 1'b0;
        checks += 3;
        if (obs_finish !== 1'b0) begin errors++; $display("FAIL midhash_rst_finish got=%b exp=0", obs_finish); end
        if (obs_found  !== 1'b0) begin errors++; $display("FAIL midhash_rst_found got=%b exp=0", obs_found); end
        if (obs_nonce  !== 32'd0) begin errors++; $display("FAIL midhash_rst_nonce got=%h exp=0", obs_nonce); end
        // fresh search from IDLE, then reset while in DONE with found=1
        launch(1, zero_blk, 16'hFFFF, MAX_B);
        await_finish(0, 200, lat);
        e = sb.pop_front();
        checks += 2;
        if (lat !== e.lat)         begin errors++; $display("FAIL postreset_latency got=%0d exp=%0d", lat, e.lat); end
        if (obs_found !== e.found) begin errors++; $display("FAIL postreset_found got=%b exp=%b", obs_found, e.found); end
        step(); step();
        rst = 1'b1; go[1] = 1'b0;
        step();
        rst = 1'b0;
        checks += 3;
        if (obs_finish !== 1'b0) begin errors++; $display("FAIL done_rst_finish got=%b exp=0", obs_finish); end
        if (obs_found  !== 1'b0) begin errors++; $display("FAIL done_rst_found got=%b exp=0", obs_found); end
        if (obs_nonce  !== 32'd0) begin errors++; $display("FAIL done_rst_nonce got=%h exp=0", obs_nonce); end
    endtask

    initial begin
        test_reset();
        test_found_nonce0();
        test_strict_compare();
        test_random_block();
        test_exhaust();
        test_abort_restart();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/nonce_search.md
# nonce_search

Proof-of-work search engine for the perf_sys design. On `start` it captures a 12-byte block header and a 16-bit target. It then walks a 32-bit nonce upward from zero, running a 16-round byte hash over {block, nonce} for each value. It stops on the first nonce whose 16-bit digest is strictly below the target and reports that nonce on `nonce0..nonce3` with `finish`; the stimulus/driver side supplies the block and target.

## Interface
- `MAX_NONCE`, default 32'hFFFF_FFFF: last nonce tried before giving up; override for short simulations.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: level request; must stay high for the whole search.
- `block0..block11`  in  8 each: header bytes; must be valid in the cycle `start` is first seen high.
- `target`  in  16: success threshold; digest < target wins.
- `finish`  out  1: search complete; held while in DONE.
- `found`  out  1: 1 = digest < target; 0 = nonce space exhausted. Valid only while `finish`=1.
- `nonce0..nonce3`  out  8 each: result nonce = {nonce3, nonce2, nonce1, nonce0}, with `nonce0` the LSB. Valid while `finish`=1.

## Operation
- **States:** IDLE, HASH, CMP, DONE.
- **Reset:** state IDLE, internal nonce=0, round=0. Outputs: `finish`=0, `found`=0, `nonce0..3`=0.
- **IDLE:**
  - On `start`=1, latch block0..11 and target, set nonce=0, init a=8'h01, b=8'h89, c=8'hFE, round=0, go HASH.
- **Hash input:** W[0..11] = block0..block11; W[12..15] = nonce bytes, LSB first.
- **HASH:** one round per cycle, i = 0..15, all mod 256. With k = W[i]:
  - a' = b
  - b' = c ^ k
  - c' = a + b + {k[4:0], k[7:5]} (rotate left 3)
  - After round 15, go CMP.
- **CMP:** digest H = {b, c}.
  - If H < latched target (unsigned): go DONE with `found`=1 and the nonce registered to the outputs.
  - Else if nonce == MAX_NONCE: go DONE with `found`=0 and outputs = MAX_NONCE.
  - Else: nonce+1, re-init a, b, c and round=0, go HASH.
- **DONE:**
  - `finish`=1; `found` and nonce outputs stable.
  - When `start`=0, go IDLE: `finish`=0 and `found`=0 next cycle. Nonce outputs keep the last result.
- **Abort:** `start`=0 in HASH or CMP returns to IDLE next cycle. `finish` is never asserted; nonce outputs are unchanged.
- **Ignored inputs:** block and target changes after the latch cycle are ignored until the next IDLE→HASH.
- **Target 0:** never succeeds; the block searches to MAX_NONCE.
- **Nonce wrap:** the nonce never wraps; MAX_NONCE = 32'hFFFF_FFFF is still tested, then `found`=0.
- **Reset priority:** `reset` overrides everything in any state, including mid-HASH and DONE.

## Timing
- Let cycle 0 be the edge where IDLE samples `start`=1.
- Rounds occupy cycles 1..16 and CMP is cycle 17: 17 cycles per nonce.
- Success at nonce N: `finish` first high after edge 17(N+1)+1 (nonce 0 → edge 18).
- Exhaustion: `finish` high after edge 17(MAX_NONCE+1)+1.
- DONE→IDLE: `finish` falls one cycle after `start` is sampled low.
- Restart: a new search may begin the cycle after IDLE is re-entered.
- `start` held high continuously through DONE does not restart a search.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Block all 8'h00, target 16'hAA0C → H(nonce 0)=16'hAA0B; `finish`=1, `found`=1, nonce=0 at edge 18.
- Block all 8'h00, target 16'hAA0B, MAX_NONCE=0 → strict compare fails; `finish` at edge 18, `found`=0, nonce=0.
- Block eb,ad,50,90,38,43,f9,c9,aa,ad,6f,64 (block0..11), target 50 → `finish`/`found`/nonce match the bit-exact software model, including the 17(N+1)+1 latency.
- Target 0, MAX_NONCE=3 → `finish` at edge 69, `found`=0, nonce=3; drop `start` → `finish`=0 next cycle.
- `start` dropped at cycle 10 of a search → IDLE; `finish` stays 0. Restart with target 16'hAA0C and zero block → `finish` 18 cycles after restart.
- `reset` pulsed mid-HASH and again in DONE → all outputs 0 next cycle, state IDLE.
